reg_scoreboard: RTL
===================

REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Interface
REQ-001 SHALL have parameter MAX_PEND, default 3, meaning max in-flight writes tracked per register (counter width = clog2(MAX_PEND+1)).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on posedge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port issue_valid  input  1  decode stage presents an instruction.
REQ-005 SHALL have port issue_rs  input  5  first source register index.
REQ-006 SHALL have port issue_rt  input  5  second source register index.
REQ-007 SHALL have port issue_use_rs  input  1  instruction reads issue_rs.
REQ-008 SHALL have port issue_use_rt  input  1  instruction reads issue_rt.
REQ-009 SHALL have port issue_regwrite  input  1  instruction will write the register file.
REQ-010 SHALL have port issue_rd  input  5  destination register index.
REQ-011 SHALL have port stall  output  1  issue blocked this cycle.
REQ-012 SHALL have port wb_regwrite  input  1  writeback stage writes register file this cycle.
REQ-013 SHALL have port wb_rd  input  5  writeback destination index.
REQ-014 SHALL have port busy_mask  output  32  bit i = 1 when register i has pending count > 0.
REQ-015 SHALL have port wb_underflow  output  1  sticky error: writeback to register with zero pending count.

Function
REQ-016 SHALL keep one pending counter per register 1..31; register 0 has no counter and busy_mask[0] is constant 0.
REQ-017 SHALL assert stall combinationally = issue_valid & (rs_hazard | rt_hazard | dest_full), evaluated from registered counters only.
REQ-018 SHALL define rs_hazard = issue_use_rs & issue_rs != 0 & count[issue_rs] > 0; rt_hazard likewise.
REQ-019 SHALL define dest_full = issue_regwrite & issue_rd != 0 & count[issue_rd] == MAX_PEND.
REQ-020 SHALL treat issue as accepted when issue_valid & ~stall; stall SHALL be 0 when issue_valid is 0.
REQ-021 SHALL increment count[issue_rd] by 1 on an accepted issue with issue_regwrite=1 and issue_rd != 0.
REQ-022 SHALL decrement count[wb_rd] by 1 when wb_regwrite=1, wb_rd != 0 and count > 0.
REQ-023 SHALL leave the count unchanged when increment and decrement target the same register in the same cycle.
REQ-024 SHALL NOT let a same-cycle writeback clear a source hazard; the stall drops the following cycle (1-cycle latency from WB to unblock).
REQ-025 SHALL ignore issue_rd=0 and wb_rd=0 entirely (no count change, no error).
REQ-026 SHALL set wb_underflow on wb_regwrite=1, wb_rd != 0, count[wb_rd]==0 and hold it until reset; that counter stays 0.
REQ-027 SHALL never wrap counters: saturation is prevented by dest_full, underflow by REQ-026.
REQ-028 SHALL update busy_mask one cycle after the counter change (busy_mask is decoded from registered counters).

Reset
REQ-029 SHALL, on rst=1 at posedge clk, clear all counters, busy_mask=0, wb_underflow=0; stall then depends only on inputs and reads 0 for any source.
REQ-030 SHALL give rst priority over same-cycle issue and writeback (both discarded).
REQ-031 SHALL apply reset mid-operation identically: in-flight pending writes are forgotten.

Structure
REQ-032 SHALL place MAX_PEND default, register-count constant (32) and the zero-register index in the shared CPU package.
REQ-033 SHALL implement one sub-module, pend_counter (single saturating up/down counter with inc, dec, count, nonzero), instantiated 31 times.

Verification
REQ-034 SHALL test: reset, then issue rd=8 regwrite -> next cycle busy_mask[8]=1; issue use_rs rs=8 -> stall=1.
REQ-035 SHALL test: wb_rd=8 in same cycle as dependent issue -> stall=1 that cycle, stall=0 next cycle, busy_mask[8]=0.
REQ-036 SHALL test: three accepted issues rd=9 (MAX_PEND=3), fourth issue rd=9 -> stall=1; one wb_rd=9 -> fourth accepted next cycle.
REQ-037 SHALL test: accepted issue rd=10 and wb_rd=10 same cycle with count 1 -> count stays 1, busy_mask[10]=1.
REQ-038 SHALL test: issue rd=0 and source rs=0 -> never stall, busy_mask=0; wb_rd=12 with count 0 -> wb_underflow=1 until rst.
REQ-039 SHALL test: rst asserted with counts pending and concurrent issue -> all busy_mask bits 0 next cycle, no stall on any source.

Source files
------------

// File: rtl/reg_scoreboard_pkg.sv
// reg_scoreboard_pkg: shared CPU register-file constants for the issue scoreboard
package reg_scoreboard_pkg;
  localparam int NUM_REGS = 32;
  localparam int REG_W = $clog2(NUM_REGS);
  localparam int ZERO_REG = 0;
  localparam int MAX_PEND_DEF = 3;
endpackage

// File: rtl/pend_counter.sv
// pend_counter: per-register pending-write counter that never wraps in either direction
module pend_counter #(
  parameter int MAX_PEND = 3,
  parameter int W = $clog2(MAX_PEND + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         nonzero
);
  always_ff @(posedge clk)
    if (rst) count <= '0;
    else if (inc && !dec && count != W'(MAX_PEND)) count <= count + 1'b1;
    else if (dec && !inc && count != '0) count <= count - 1'b1;
  assign nonzero = count != '0;
endmodule

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: tracks in-flight register writes and stalls issue on RAW hazards or a full counter
module reg_scoreboard
  import reg_scoreboard_pkg::*;
#(
  parameter int MAX_PEND = MAX_PEND_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                issue_valid,
  input  logic [REG_W-1:0]    issue_rs,
  input  logic [REG_W-1:0]    issue_rt,
  input  logic                issue_use_rs,
  input  logic                issue_use_rt,
  input  logic                issue_regwrite,
  input  logic [REG_W-1:0]    issue_rd,
  output logic                stall,
  input  logic                wb_regwrite,
  input  logic [REG_W-1:0]    wb_rd,
  output logic [NUM_REGS-1:0] busy_mask,
  output logic                wb_underflow
);
  localparam int W = $clog2(MAX_PEND + 1);
  localparam logic [REG_W-1:0] ZR = REG_W'(ZERO_REG);
  logic [W-1:0] cnt [NUM_REGS];
  logic [NUM_REGS-1:0] nz;
  logic rs_hazard, rt_hazard, dest_full, accept;
  assign rs_hazard = issue_use_rs && issue_rs != ZR && nz[issue_rs];
  assign rt_hazard = issue_use_rt && issue_rt != ZR && nz[issue_rt];
  assign dest_full = issue_regwrite && issue_rd != ZR && cnt[issue_rd] == W'(MAX_PEND);
  assign stall = issue_valid && (rs_hazard || rt_hazard || dest_full);
  assign accept = issue_valid && !stall;
  assign busy_mask = nz;
  genvar i;
  generate
    for (i = 0; i < NUM_REGS; i++) begin : g_reg
      if (i == ZERO_REG) begin : g_zero
        assign cnt[i] = '0;
        assign nz[i] = 1'b0;
      end else begin : g_cnt
        pend_counter #(.MAX_PEND(MAX_PEND), .W(W)) u_cnt (
          .clk(clk),
          .rst(rst),
          .inc(accept && issue_regwrite && issue_rd == REG_W'(i)),
          .dec(wb_regwrite && wb_rd == REG_W'(i)),
          .count(cnt[i]),
          .nonzero(nz[i])
        );
      end
    end
  endgenerate
  // sticky until reset; the counter itself refuses to go below zero
  always_ff @(posedge clk)
    if (rst) wb_underflow <= 1'b0;
    else if (wb_regwrite && wb_rd != ZR && !nz[wb_rd]) wb_underflow <= 1'b1;
endmodule
